// File: rtl/alu_muldiv_unit_pkg.sv
// Shared CPU definitions for the multiply/divide unit: decode op-codes and FSM states.
// Helper predicates keep the op-code classification in one place.
package alu_muldiv_unit_pkg;

    localparam logic [5:0] ALU_MULT  = 6'h18;
    localparam logic [5:0] ALU_MULTU = 6'h19;
    localparam logic [5:0] ALU_DIV   = 6'h1A;
    localparam logic [5:0] ALU_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    function automatic logic is_muldiv_op(input logic [5:0] ctrl);
        return (ctrl == ALU_MULT) || (ctrl == ALU_MULTU) ||
               (ctrl == ALU_DIV)  || (ctrl == ALU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [5:0] ctrl);
        return (ctrl == ALU_DIV) || (ctrl == ALU_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [5:0] ctrl);
        return (ctrl == ALU_MULT) || (ctrl == ALU_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring divide.
// Multiply: {hi,lo} = {product-high, multiplier}; divide: hi = remainder, lo = dividend/quotient.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_acc_hi,
    input  logic [WIDTH-1:0] i_acc_lo,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;

    assign w_sum    = {1'b0, i_acc_hi} + (i_acc_lo[0] ? {1'b0, i_opnd} : '0);
    assign w_rem_sh = {i_acc_hi, i_acc_lo[WIDTH-1]};
    // remainder stays below the divisor, so bit WIDTH of the difference is a clean borrow flag
    assign w_diff   = w_rem_sh - {1'b0, i_opnd};

    always_comb begin
        o_hi = w_sum[WIDTH:1];
        o_lo = {w_sum[0], i_acc_lo[WIDTH-1:1]};
        if (i_is_div) begin
            if (!w_diff[WIDTH]) begin
                o_hi = w_diff[WIDTH-1:0];
                o_lo = {i_acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_hi = w_rem_sh[WIDTH-1:0];
                o_lo = {i_acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: magnitude datapath, one bit per cycle, sign fix at completion.
//   state   | meaning
//   IDLE    | ready for a request
//   RUN     | WIDTH datapath iterations, counter WIDTH-1 down to 0
//   DONE    | one-cycle result pulse, outputs captured
module alu_muldiv_unit
    import alu_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    muldiv_state_t      r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div, r_neg_res, r_neg_rem, r_dz, r_div_zero;
    logic [WIDTH-1:0]   r_acc_hi, r_acc_lo, r_opnd, r_hi, r_lo;
    logic               w_accept, w_req_div, w_req_signed, w_b_zero;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_step_hi, w_step_lo, w_res_hi, w_res_lo;
    logic [2*WIDTH-1:0] w_prod, w_prod_neg;

    assign w_req_div    = is_div_op(alu_ctrl);
    assign w_req_signed = is_signed_op(alu_ctrl);
    assign w_b_zero     = (b == '0);
    assign w_a_mag      = (w_req_signed && a[WIDTH-1]) ? -a : a;
    assign w_b_mag      = (w_req_signed && b[WIDTH-1]) ? -b : b;

    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_valid && in_ready && is_muldiv_op(alu_ctrl) && !flush;
    assign done     = (r_state == ST_DONE) && !flush;

    // held registers are bypassed during the done pulse so results appear in the DONE cycle
    assign hi       = done ? w_res_hi : r_hi;
    assign lo       = done ? w_res_lo : r_lo;
    assign div_zero = done ? r_dz : r_div_zero;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (r_is_div),
        .i_acc_hi (r_acc_hi),
        .i_acc_lo (r_acc_lo),
        .i_opnd   (r_opnd),
        .o_hi     (w_step_hi),
        .o_lo     (w_step_lo)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = (w_req_div && w_b_zero) ? ST_DONE : ST_RUN;
            ST_RUN: begin
                if (flush)              w_state_nxt = ST_IDLE;
                else if (r_cnt == '0)   w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_prod     = {r_acc_hi, r_acc_lo};
        w_prod_neg = -w_prod;
        w_res_hi   = r_acc_hi;
        w_res_lo   = r_acc_lo;
        if (!r_dz) begin
            if (r_is_div) begin
                if (r_neg_res) w_res_lo = -r_acc_lo;
                if (r_neg_rem) w_res_hi = -r_acc_hi;
            end else if (r_neg_res) begin
                {w_res_hi, w_res_lo} = w_prod_neg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_dz       <= 1'b0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_opnd     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_is_div  <= w_req_div;
                r_neg_res <= w_req_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg_rem <= w_req_signed && a[WIDTH-1];
                r_dz      <= w_req_div && w_b_zero;
                r_cnt     <= CW'(WIDTH - 1);
                if (w_req_div && w_b_zero) begin
                    r_acc_hi <= a;
                    r_acc_lo <= '1;
                end else if (w_req_div) begin
                    r_acc_hi <= '0;
                    r_acc_lo <= w_a_mag;
                    r_opnd   <= w_b_mag;
                end else begin
                    r_acc_hi <= '0;
                    r_acc_lo <= w_b_mag;
                    r_opnd   <= w_a_mag;
                end
            end else if (r_state == ST_RUN && !flush) begin
                r_acc_hi <= w_step_hi;
                r_acc_lo <= w_step_lo;
                if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            end
            if (done) begin
                r_hi       <= w_res_hi;
                r_lo       <= w_res_lo;
                r_div_zero <= r_dz;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed-vector bench for alu_muldiv_unit (WIDTH=32) with hand-computed expectations.
module tb_alu_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, done, div_zero;
    logic [5:0]  alu_ctrl;
    logic [31:0] a, b, hi, lo;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;

    alu_muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_ctrl (alu_ctrl),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drives one request, returns the done cycle index (1 = cycle after accept) and the accept cycle.
    task automatic run_op(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv,
                          output int lat, output int acc_cyc);
        @(posedge clk);
        #1 in_valid = 1'b1; alu_ctrl = op; a = av; b = bv;
        @(posedge clk);
        #1 in_valid = 1'b0; acc_cyc = cyc;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
    endtask

    initial begin
        int lat, t0, t1, cnt_done, cnt_busy;
        logic [31:0] hold_hi, hold_lo;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; alu_ctrl = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", in_ready, 1);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_dz", div_zero, 0);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, t0);
        check("multu_lat", lat, 33);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        check("multu_dz", div_zero, 0);
        check("multu_busy", in_ready, 0);
        @(negedge clk);
        check("multu_pulse", done, 0);
        check("multu_hold_hi", hi, 32'hFFFF_FFFE);

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, lat, t0);
        check("mult_lat", lat, 33);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, t0);
        check("div_q", lo, 32'hFFFF_FFFD);
        check("div_r", hi, 32'hFFFF_FFFF);

        run_op(OP_DIVU, 32'd100, 32'd0, lat, t0);
        check("dz_lat", lat, 1);
        check("dz_lo", lo, 32'hFFFF_FFFF);
        check("dz_hi", hi, 32'd100);
        check("dz_flag", div_zero, 1);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, t0);
        check("ovf_lat", lat, 33);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);
        check("ovf_dz", div_zero, 0);

        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, t0);
        check("div_neg_b_q", lo, 32'hFFFF_FFFD);
        check("div_neg_b_r", hi, 32'd1);

        // flush mid-RUN
        hold_hi = 32'd1; hold_lo = 32'hFFFF_FFFD;
        @(posedge clk);
        #1 in_valid = 1'b1; alu_ctrl = OP_MULTU; a = 32'd3; b = 32'd5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cnt_done = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); if (done) cnt_done++;
            @(posedge clk);
        end
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_ready", in_ready, 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); if (done) cnt_done++;
        end
        check("flush_no_done", cnt_done, 0);
        check("flush_hi", hi, hold_hi);
        check("flush_lo", lo, hold_lo);

        // flush in IDLE blocks accept
        @(posedge clk);
        #1 in_valid = 1'b1; alu_ctrl = OP_MULTU; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("idle_flush_block", in_ready, 1);

        // unrecognised code never accepted
        @(posedge clk);
        #1 in_valid = 1'b1; alu_ctrl = 6'h20; a = 32'd9; b = 32'd3;
        cnt_done = 0; cnt_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) cnt_done++;
            if (!in_ready) cnt_busy++;
        end
        #1 in_valid = 1'b0;
        check("illegal_done", cnt_done, 0);
        check("illegal_busy", cnt_busy, 0);

        // back-to-back
        run_op(OP_DIVU, 32'd100, 32'd7, lat, t0);
        check("b2b1_cyc", cyc - t0 + 1, 33);
        check("b2b1_lo", lo, 32'd14);
        check("b2b1_hi", hi, 32'd2);
        run_op(OP_MULTU, 32'd6, 32'd7, lat, t1);
        check("b2b2_cyc", cyc - t0 + 1, 67);
        check("b2b2_lo", lo, 32'd42);
        check("b2b2_hi", hi, 32'd0);

        // reset mid-RUN
        @(posedge clk);
        #1 in_valid = 1'b1; alu_ctrl = OP_MULTU; a = 32'd11; b = 32'd13;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("mrst_ready", in_ready, 1);
        check("mrst_done", done, 0);
        check("mrst_hi", hi, 0);
        check("mrst_lo", lo, 0);
        check("mrst_dz", div_zero, 0);

        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, lat, t0);
        check("post_rst_lat", lat, 33);
        check("post_rst_hi", hi, 32'h4000_0000);
        check("post_rst_lo", lo, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
